// File: rtl/spi_shift_if.sv
// spi_shift_if: bus bundle between the APB SPI register block and the shift engine.
//
// Signals (driven by master, unless marked engine-driven):
//   ss, load, tx_data, frame_len, lsbfe, cpol, cpha  : frame control from software
//   flag_low, flag_high                              : sample strobes (one PCLK per SCLK edge)
//   flags_low, flags_high                            : launch strobes (one PCLK ahead of SCLK edge)
//   miso                                             : serial data in
//   mosi, rx_data, rx_valid, busy, load_err, tx_cnt  : engine-driven results and status
interface spi_shift_if #(
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic              ss;
  logic              load;
  logic [DATA_W-1:0] tx_data;
  logic [CNT_W-1:0]  frame_len;
  logic              lsbfe;
  logic              cpol;
  logic              cpha;
  logic              flag_low;
  logic              flag_high;
  logic              flags_low;
  logic              flags_high;
  logic              miso;
  logic              mosi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              load_err;
  logic [CNT_W-1:0]  tx_cnt;

  modport master (
    output ss, load, tx_data, frame_len, lsbfe, cpol, cpha,
           flag_low, flag_high, flags_low, flags_high, miso,
    input  mosi, rx_data, rx_valid, busy, load_err, tx_cnt
  );

  modport slave (
    input  ss, load, tx_data, frame_len, lsbfe, cpol, cpha,
           flag_low, flag_high, flags_low, flags_high, miso,
    output mosi, rx_data, rx_valid, busy, load_err, tx_cnt
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: serialises a transmit word onto mosi and deserialises miso
// into a receive word, with run-time frame length, bit order and SPI mode.
//
// Ports:
//   PCLK    : APB clock
//   PRESETn : asynchronous active-low reset
//   bus     : spi_shift_if.slave bundle (control, strobes, serial lines, status)
//
// All outputs are registered. Frames repeat back-to-back while ss stays low;
// raising ss aborts the current frame without touching rx_data or tx_reg.
module spi_shift_engine #(
  parameter int DATA_W = 8
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  spi_shift_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] tx_reg, tx_reg_nxt;
  logic [DATA_W-1:0] rx_shift, rx_shift_nxt;
  logic [DATA_W-1:0] rx_data, rx_data_nxt;
  logic [CNT_W-1:0]  n_lat, n_lat_nxt;
  logic [CNT_W-1:0]  tx_cnt, tx_cnt_nxt;
  logic [CNT_W-1:0]  rx_cnt, rx_cnt_nxt;
  logic              mosi, mosi_nxt;
  logic              rx_valid, rx_valid_nxt;
  logic              busy, busy_nxt;
  logic              load_err, load_err_nxt;

  logic              launch, sample, completing, load_ok;
  logic [CNT_W-1:0]  n_eff, tx_idx, rx_idx;
  logic [DATA_W-1:0] len_mask;

  // Position of the k-th transferred bit inside an N-bit frame.
  function automatic logic [CNT_W-1:0] bit_idx(input logic [CNT_W-1:0] k,
                                               input logic [CNT_W-1:0] n,
                                               input logic             lsb);
    return lsb ? k : (n - k - CNT_W'(1));
  endfunction

  always_comb begin
    // Modes 1 and 2 both work on the high strobes, modes 0 and 3 on the low ones.
    launch     = (bus.cpol ^ bus.cpha) ? bus.flags_high : bus.flags_low;
    sample     = (bus.cpol ^ bus.cpha) ? bus.flag_high  : bus.flag_low;
    n_eff      = (bus.frame_len == '0 || bus.frame_len > CNT_W'(DATA_W)) ?
                 CNT_W'(DATA_W) : bus.frame_len;
    // The cycle after the last sample: result is published, a reload is allowed.
    completing = (state == SHIFT) && (rx_cnt == n_lat) && !bus.ss;
    load_ok    = bus.load && ((state != SHIFT) || completing);
    tx_idx     = bit_idx(tx_cnt, n_lat, bus.lsbfe);
    rx_idx     = bit_idx(rx_cnt, n_lat, bus.lsbfe);
    for (int i = 0; i < DATA_W; i++) len_mask[i] = (CNT_W'(i) < n_lat);
  end

  always_comb begin
    state_nxt    = state;
    tx_reg_nxt   = tx_reg;
    rx_shift_nxt = rx_shift;
    rx_data_nxt  = rx_data;
    n_lat_nxt    = n_lat;
    tx_cnt_nxt   = tx_cnt;
    rx_cnt_nxt   = rx_cnt;
    mosi_nxt     = mosi;
    rx_valid_nxt = 1'b0;
    load_err_nxt = 1'b0;

    unique case (state)
      IDLE: ;
      ARMED: begin
        // A load in the same cycle wins; the launch is taken on the next strobe.
        if (!bus.ss && launch && !bus.load && tx_cnt < n_lat) begin
          for (int i = 0; i < DATA_W; i++)
            if (CNT_W'(i) == tx_idx) mosi_nxt = tx_reg[i];
          tx_cnt_nxt = tx_cnt + CNT_W'(1);
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (completing) begin
          rx_data_nxt  = rx_shift & len_mask;
          rx_valid_nxt = 1'b1;
          tx_cnt_nxt   = '0;
          rx_cnt_nxt   = '0;
          state_nxt    = ARMED;
        end else begin
          if (launch && tx_cnt < n_lat) begin
            for (int i = 0; i < DATA_W; i++)
              if (CNT_W'(i) == tx_idx) mosi_nxt = tx_reg[i];
            tx_cnt_nxt = tx_cnt + CNT_W'(1);
          end
          if (sample && rx_cnt < n_lat) begin
            for (int i = 0; i < DATA_W; i++)
              if (CNT_W'(i) == rx_idx) rx_shift_nxt[i] = bus.miso;
            rx_cnt_nxt = rx_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Slave deselect aborts whatever was in flight; tx_reg and rx_data survive.
    if (bus.ss) begin
      mosi_nxt     = 1'b0;
      tx_cnt_nxt   = '0;
      rx_cnt_nxt   = '0;
      rx_shift_nxt = '0;
      if (state == SHIFT) state_nxt = ARMED;
    end

    if (load_ok) begin
      tx_reg_nxt = bus.tx_data;
      n_lat_nxt  = n_eff;
      tx_cnt_nxt = '0;
      rx_cnt_nxt = '0;
      state_nxt  = ARMED;
    end else if (bus.load) begin
      load_err_nxt = 1'b1;
    end

    busy_nxt = (state_nxt == SHIFT);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      tx_reg   <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      n_lat    <= CNT_W'(DATA_W);
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_reg   <= tx_reg_nxt;
      rx_shift <= rx_shift_nxt;
      rx_data  <= rx_data_nxt;
      n_lat    <= n_lat_nxt;
      tx_cnt   <= tx_cnt_nxt;
      rx_cnt   <= rx_cnt_nxt;
      mosi     <= mosi_nxt;
      rx_valid <= rx_valid_nxt;
      busy     <= busy_nxt;
      load_err <= load_err_nxt;
    end
  end

  assign bus.mosi     = mosi;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign bus.busy     = busy;
  assign bus.load_err = load_err;
  assign bus.tx_cnt   = tx_cnt;
endmodule
